// File: rtl/ber_ctrl_pkg.sv
// Shared types and constants for the BER run sequencer.
package ber_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_DRAIN,
    ST_SNAP,
    ST_DONE
  } state_t;

  // done_reason encoding
  localparam logic [1:0] REASON_NONE       = 2'd0;
  localparam logic [1:0] REASON_FRAME_ERR  = 2'd1;
  localparam logic [1:0] REASON_BIT_BUDGET = 2'd2;
  localparam logic [1:0] REASON_ABORT      = 2'd3;

  // Probability index value that tells parallel_sys1 "no table write".
  localparam logic [31:0] PROB_IDX_NONE = 32'hFFFF_FFFF;

  // Width of the shared wait/index timer; covers every cycle count used here.
  localparam int TIMER_W = 8;

endpackage

// File: rtl/ber_cycle_timer.sv
// Loadable down-counter with a zero flag. Shared by the CLEAR, SETTLE and
// DRAIN waits and used as the LOAD index source.
module ber_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ber_run_controller.sv
// Run sequencer around parallel_sys1: clear, load the probability table,
// run until a stop condition, drain the pipeline and freeze the counters.
module ber_run_controller
  import ber_ctrl_pkg::*;
#(
  parameter int  CNT_W         = 64,
  parameter int  PROB_W        = 64,
  parameter int  N_PROB        = 2,
  parameter int  CLEAR_CYCLES  = 4,
  parameter int  SETTLE_CYCLES = 4,
  parameter int  DRAIN_CYCLES  = 16,
  localparam int ADDR_W        = $clog2(N_PROB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_wr,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [PROB_W-1:0] cfg_data,
  input  logic [CNT_W-1:0]  target_frame_errors,
  input  logic [CNT_W-1:0]  max_bits,
  output logic              sys_en,
  output logic              sys_rstn,
  output logic [31:0]       sys_probability_idx,
  output logic [PROB_W-1:0] sys_probability_in,
  input  logic [CNT_W-1:0]  total_bits,
  input  logic [CNT_W-1:0]  total_bit_errors_pre,
  input  logic [CNT_W-1:0]  total_bit_errors_post,
  input  logic [CNT_W-1:0]  total_frames,
  input  logic [CNT_W-1:0]  total_frame_errors,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_reason,
  output logic [CNT_W-1:0]  snap_bits,
  output logic [CNT_W-1:0]  snap_err_pre,
  output logic [CNT_W-1:0]  snap_err_post,
  output logic [CNT_W-1:0]  snap_frames,
  output logic [CNT_W-1:0]  snap_frame_err
);

  state_t              state;
  logic                hit_fe;
  logic                hit_mb;
  logic [PROB_W-1:0]   shadow [N_PROB];

  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;
  logic [TIMER_W-1:0]  tmr_count;
  logic                tmr_zero;

  logic                quiet;
  logic                start_now;
  logic                abort_now;
  logic                hit_now;
  logic [TIMER_W-1:0]  next_k;

  assign quiet     = (state == ST_IDLE) || (state == ST_DONE);
  assign start_now = start && quiet;
  assign abort_now = abort && ((state == ST_CLEAR) || (state == ST_LOAD) ||
                               (state == ST_SETTLE) || (state == ST_RUN));
  assign hit_now   = (state == ST_RUN) && (hit_fe || hit_mb);
  // In LOAD the timer counts N_PROB-1 down to 0, so the entry shown on the
  // next cycle is N_PROB minus the current count.
  assign next_k    = TIMER_W'(N_PROB) - tmr_count;

  ber_cycle_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Timer reload on entry to each timed state; otherwise it free-runs down.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (start_now) begin
      tmr_load = 1'b1;
      tmr_val  = TIMER_W'(CLEAR_CYCLES - 1);
    end else if (abort_now || hit_now) begin
      tmr_load = 1'b1;
      tmr_val  = TIMER_W'(DRAIN_CYCLES - 1);
    end else if (tmr_zero && (state == ST_CLEAR)) begin
      tmr_load = 1'b1;
      tmr_val  = TIMER_W'(N_PROB - 1);
    end else if (tmr_zero && (state == ST_LOAD)) begin
      tmr_load = 1'b1;
      tmr_val  = TIMER_W'(SETTLE_CYCLES - 1);
    end
  end

  // Shadow probability table: host writes are taken only while not running.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this table is tiny and must read back as zeros after reset,
      // so it is cleared explicitly instead of relying on power-up contents.
      for (int i = 0; i < N_PROB; i++) shadow[i] <= '0;
    end else if (cfg_wr && quiet && (int'(cfg_addr) < N_PROB)) begin
      shadow[cfg_addr] <= cfg_data;
    end
  end

  // Run sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      sys_en              <= 1'b0;
      sys_rstn            <= 1'b0;
      sys_probability_idx <= PROB_IDX_NONE;
      sys_probability_in  <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      done_reason         <= REASON_NONE;
      hit_fe              <= 1'b0;
      hit_mb              <= 1'b0;
      snap_bits           <= '0;
      snap_err_pre        <= '0;
      snap_err_post       <= '0;
      snap_frames         <= '0;
      snap_frame_err      <= '0;
    end else begin
      hit_fe <= 1'b0;
      hit_mb <= 1'b0;
      if (abort_now) begin
        // Abort beats any coincident limit hit and abandons a partial LOAD.
        state               <= ST_DRAIN;
        done_reason         <= REASON_ABORT;
        sys_en              <= 1'b0;
        sys_rstn            <= 1'b1;
        sys_probability_idx <= PROB_IDX_NONE;
        sys_probability_in  <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start_now) begin
              state       <= ST_CLEAR;
              sys_rstn    <= 1'b0;
              sys_en      <= 1'b0;
              busy        <= 1'b1;
              done        <= 1'b0;
              done_reason <= REASON_NONE;
            end
          end
          ST_CLEAR: begin
            if (tmr_zero) begin
              state               <= ST_LOAD;
              sys_rstn            <= 1'b1;
              sys_probability_idx <= 32'd0;
              sys_probability_in  <= shadow[0];
            end
          end
          ST_LOAD: begin
            if (tmr_zero) begin
              state               <= ST_SETTLE;
              sys_probability_idx <= PROB_IDX_NONE;
              sys_probability_in  <= '0;
            end else begin
              sys_probability_idx <= 32'(next_k);
              sys_probability_in  <= shadow[next_k[ADDR_W-1:0]];
            end
          end
          ST_SETTLE: begin
            if (tmr_zero) begin
              state  <= ST_RUN;
              sys_en <= 1'b1;
            end
          end
          ST_RUN: begin
            hit_fe <= (target_frame_errors != '0) && (total_frame_errors >= target_frame_errors);
            hit_mb <= (max_bits != '0) && (total_bits >= max_bits);
            if (hit_now) begin
              state       <= ST_DRAIN;
              sys_en      <= 1'b0;
              done_reason <= hit_fe ? REASON_FRAME_ERR : REASON_BIT_BUDGET;
            end
          end
          ST_DRAIN: begin
            if (tmr_zero) state <= ST_SNAP;
          end
          ST_SNAP: begin
            state          <= ST_DONE;
            busy           <= 1'b0;
            done           <= 1'b1;
            snap_bits      <= total_bits;
            snap_err_pre   <= total_bit_errors_pre;
            snap_err_post  <= total_bit_errors_post;
            snap_frames    <= total_frames;
            snap_frame_err <= total_frame_errors;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
